// File: rtl/cc_pong_defs_pkg.sv
// Shared pong constants: FSM state encoding, serve position and the
// row limit patterns also used by the side comparator.
package cc_pong_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_MOVE_LEFT  = 2'd1,
        ST_MOVE_RIGHT = 2'd2,
        ST_MISS       = 2'd3
    } state_t;

    localparam int         START_POS   = 5;
    localparam logic [7:0] LEFT_LIMIT  = 8'b1000_0000;
    localparam logic [7:0] RIGHT_LIMIT = 8'b0001_0000;

endpackage

// File: rtl/cc_step_prescaler.sv
// Free-running step prescaler: counts 0..MAX-1 and raises a step
// strobe on the last count; held at zero while clear is high.
module cc_step_prescaler #(
    parameter int WIDTH = 24,
    parameter int MAX   = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic step
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] count;

    // counter wraps on its last value, restarts from zero on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign step = !clear && (count == LAST);

endmodule

// File: rtl/cc_ball_shifter_jug1.sv
// Player-1 ball row generator: serves, shifts one LED per step,
// bounces on the paddle at either limit and flags a miss otherwise.
module cc_ball_shifter_jug1
    import cc_pong_defs_pkg::*;
#(
    parameter int DATAWIDTH       = 8,
    parameter int PRESCALER_WIDTH = 24,
    parameter int PRESCALER_MAX   = 12_500_000
) (
    input  logic                 CC_BALLSHIFTER_JUG1_CLOCK_50,
    input  logic                 CC_BALLSHIFTER_JUG1_RESET_InHigh,
    input  logic                 CC_BALLSHIFTER_JUG1_start_InLow,
    input  logic                 CC_BALLSHIFTER_JUG1_izquierda_InLow,
    input  logic                 CC_BALLSHIFTER_JUG1_derecha_InLow,
    input  logic                 CC_BALLSHIFTER_JUG1_paddle_InHigh,
    output logic [DATAWIDTH-1:0] CC_BALLSHIFTER_JUG1_data_OutBUS,
    output logic                 CC_BALLSHIFTER_JUG1_miss_OutHigh,
    output logic                 CC_BALLSHIFTER_JUG1_busy_OutHigh
);

    localparam logic [DATAWIDTH-1:0] START_DATA =
        DATAWIDTH'(1) << START_POS;

    logic clk;
    logic rst;
    assign clk = CC_BALLSHIFTER_JUG1_CLOCK_50;
    assign rst = CC_BALLSHIFTER_JUG1_RESET_InHigh;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] data;
    logic [DATAWIDTH-1:0] data_next;
    logic [DATAWIDTH-1:0] shifted;
    logic                 miss;
    logic                 miss_next;
    logic                 busy;
    logic                 busy_next;
    logic                 go_miss;
    logic                 left_edge;
    logic [2:0]           start_sync;
    logic                 serve;
    logic                 moving;
    logic                 step;

    function automatic logic is_onehot(input logic [DATAWIDTH-1:0] v);
        return (v != '0) && ((v & (v - DATAWIDTH'(1))) == '0);
    endfunction

    // two-stage synchronizer plus one history bit for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '1;
        end else begin
            start_sync <= {start_sync[1:0], CC_BALLSHIFTER_JUG1_start_InLow};
        end
    end

    assign serve  = start_sync[2] && !start_sync[1];
    assign moving = (state == ST_MOVE_LEFT) || (state == ST_MOVE_RIGHT);

    cc_step_prescaler #(
        .WIDTH (PRESCALER_WIDTH),
        .MAX   (PRESCALER_MAX)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (!moving),
        .step  (step)
    );

    // state, ball row and status flags are all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            data  <= START_DATA;
            miss  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            data  <= data_next;
            miss  <= miss_next;
            busy  <= busy_next;
        end
    end

    // next-state and next-output logic; left limit wins if both flags low
    always_comb begin
        state_next = state;
        data_next  = data;
        miss_next  = 1'b0;
        busy_next  = busy;
        shifted    = data;
        go_miss    = 1'b0;
        left_edge  = !CC_BALLSHIFTER_JUG1_izquierda_InLow &&
                     (state == ST_MOVE_LEFT ||
                      !CC_BALLSHIFTER_JUG1_derecha_InLow);
        unique case (state)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (serve) begin
                    state_next = ST_MOVE_LEFT;
                    busy_next  = 1'b1;
                end
            end
            ST_MOVE_LEFT, ST_MOVE_RIGHT: begin
                busy_next = 1'b1;
                if (step) begin
                    if (left_edge) begin
                        if (CC_BALLSHIFTER_JUG1_paddle_InHigh) begin
                            shifted    = data >> 1;
                            state_next = ST_MOVE_RIGHT;
                        end else begin
                            go_miss = 1'b1;
                        end
                    end else if (state == ST_MOVE_LEFT) begin
                        shifted = data << 1;
                    end else if (!CC_BALLSHIFTER_JUG1_derecha_InLow) begin
                        if (CC_BALLSHIFTER_JUG1_paddle_InHigh) begin
                            shifted    = data << 1;
                            state_next = ST_MOVE_LEFT;
                        end else begin
                            go_miss = 1'b1;
                        end
                    end else begin
                        shifted = data >> 1;
                    end
                    if (!is_onehot(shifted)) begin
                        go_miss = 1'b1;
                    end
                    if (go_miss) begin
                        state_next = ST_MISS;
                        data_next  = '0;
                        miss_next  = 1'b1;
                    end else begin
                        data_next = shifted;
                    end
                end
            end
            ST_MISS: begin
                state_next = ST_IDLE;
                data_next  = START_DATA;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                data_next  = START_DATA;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign CC_BALLSHIFTER_JUG1_data_OutBUS  = data;
    assign CC_BALLSHIFTER_JUG1_miss_OutHigh = miss;
    assign CC_BALLSHIFTER_JUG1_busy_OutHigh = busy;

endmodule
